datapath_controller: RTL and testbench

Run-level sequencer and instruction decoder for the 9-bit-instruction datapath. It takes a four-phase request from the host, holds the datapath in START, then releases it to execute. While running, it decodes `opcode`/`fcode` every cycle into the `CTRL_*` strobes; outside RUN those strobes are forced to zero. It ends the run on `DONE` or on a cycle-budget timeout, reports the executed cycle count, and completes the host handshake.

---
 rtl/datapath_controller_if.sv | 51 +++++
 rtl/datapath_controller.sv | 194 +++++++++++++++++++
 tb/tb_datapath_controller.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/datapath_controller_if.sv
// Host handshake and datapath control bundle for datapath_controller.
// Latency: wires only; timing is owned by the controller.
// Backpressure: none here; host_req/host_ack is a four-phase handshake.
//
// Ports (signals):
//   host_req / host_ack       : four-phase run request / run finished
//   busy, timeout, cycle_count: run status (registered in the controller)
//   opcode, fcode, DONE       : instruction fields and end-of-program flag from the datapath
//   START                     : datapath init/freeze, active-high
//   CTRL_*                    : decoded datapath control strobes
interface datapath_controller_if;
  logic        host_req;
  logic        host_ack;
  logic        busy;
  logic        timeout;
  logic [15:0] cycle_count;
  logic [3:0]  opcode;
  logic        fcode;
  logic        DONE;
  logic        START;
  logic        CTRL_branch_rel_nz;
  logic        CTRL_branch_rel_z;
  logic        CTRL_branch_abs;
  logic        CTRL_reg_write_en;
  logic        CTRL_reg_sel;
  logic        CTRL_lut_in;
  logic        CTRL_mem_to_reg;
  logic        CTRL_alu_src;
  logic        CTRL_alu_sc_in;
  logic        CTRL_read_mem;
  logic        CTRL_write_mem;
  logic [2:0]  CTRL_alu_op;

  // Host/datapath side: drives requests and instruction fields, observes controls.
  modport master (
    output host_req, opcode, fcode, DONE,
    input  host_ack, busy, timeout, cycle_count, START,
    input  CTRL_branch_rel_nz, CTRL_branch_rel_z, CTRL_branch_abs, CTRL_reg_write_en,
    input  CTRL_reg_sel, CTRL_lut_in, CTRL_mem_to_reg, CTRL_alu_src, CTRL_alu_sc_in,
    input  CTRL_read_mem, CTRL_write_mem, CTRL_alu_op
  );

  // Controller side.
  modport slave (
    input  host_req, opcode, fcode, DONE,
    output host_ack, busy, timeout, cycle_count, START,
    output CTRL_branch_rel_nz, CTRL_branch_rel_z, CTRL_branch_abs, CTRL_reg_write_en,
    output CTRL_reg_sel, CTRL_lut_in, CTRL_mem_to_reg, CTRL_alu_src, CTRL_alu_sc_in,
    output CTRL_read_mem, CTRL_write_mem, CTRL_alu_op
  );
endinterface

// File: rtl/datapath_controller.sv
// Run sequencer (IDLE/LOAD/RUN/FINISH) plus combinational instruction decoder for the 9-bit datapath.
// Latency: request to first RUN cycle is 1+START_CYCLES edges; DONE to host_ack is one edge; CTRL is same-cycle.
// Backpressure: host holds host_req until host_ack; dropping host_req early aborts the run without ack.
//
// Ports: CLK (rising edge), reset_n (async active-low), bus (datapath_controller_if.slave):
//   status outputs START/busy/host_ack/timeout/cycle_count are registered, CTRL_* are combinational.
module datapath_controller #(
  parameter int unsigned START_CYCLES = 2,
  parameter logic [15:0] MAX_CYCLES   = 16'hFFFF
) (
  input logic                  CLK,
  input logic                  reset_n,
  datapath_controller_if.slave bus
);

  localparam int unsigned LW = $clog2(START_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_RUN    = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t        state_q;
  logic [LW-1:0] load_cnt_q;
  logic          start_q;
  logic          busy_q;
  logic          ack_q;
  logic          timeout_q;
  logic [15:0]   cycle_count_q;
  logic [15:0]   cycle_count_d;

  // Saturating run counter: parks at MAX_CYCLES instead of wrapping.
  assign cycle_count_d = (cycle_count_q == MAX_CYCLES) ? cycle_count_q : cycle_count_q + 16'd1;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      load_cnt_q    <= '0;
      start_q       <= 1'b1;
      busy_q        <= 1'b0;
      ack_q         <= 1'b0;
      timeout_q     <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.host_req) begin
            state_q       <= S_LOAD;
            load_cnt_q    <= LW'(START_CYCLES);
            cycle_count_q <= '0;
            timeout_q     <= 1'b0;
            busy_q        <= 1'b1;
            start_q       <= 1'b1;
            ack_q         <= 1'b0;
          end
        end

        S_LOAD: begin
          if (!bus.host_req) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            start_q   <= 1'b1;
            timeout_q <= 1'b0;
          end else if (load_cnt_q == LW'(1)) begin
            // START drops on the same edge that enters RUN.
            state_q <= S_RUN;
            start_q <= 1'b0;
          end else begin
            load_cnt_q <= load_cnt_q - LW'(1);
          end
        end

        S_RUN: begin
          // Every RUN cycle counts, including the one that leaves RUN.
          cycle_count_q <= cycle_count_d;
          if (!bus.host_req) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            start_q   <= 1'b1;
            timeout_q <= 1'b0;
          end else if (bus.DONE) begin
            state_q   <= S_FINISH;
            busy_q    <= 1'b0;
            start_q   <= 1'b1;
            ack_q     <= 1'b1;
            timeout_q <= 1'b0;
          end else if (cycle_count_q == MAX_CYCLES - 16'd1) begin
            state_q   <= S_FINISH;
            busy_q    <= 1'b0;
            start_q   <= 1'b1;
            ack_q     <= 1'b1;
            timeout_q <= 1'b1;
          end
        end

        S_FINISH: begin
          if (!bus.host_req) begin
            state_q <= S_IDLE;
            ack_q   <= 1'b0;
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          start_q <= 1'b1;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.START       = start_q;
  assign bus.busy        = busy_q;
  assign bus.host_ack    = ack_q;
  assign bus.timeout     = timeout_q;
  assign bus.cycle_count = cycle_count_q;

  // Decoder. The DONE term blanks the strobes on the cycle the fetch unit
  // reports end-of-program, so the last fetched word never commits.
  logic       dec_en;
  logic       br_nz, br_z, br_abs, reg_we, reg_sel, lut_in, mem_to_reg;
  logic       alu_src, alu_sc_in, rd_mem, wr_mem;
  logic [2:0] alu_op;

  assign dec_en = (state_q == S_RUN) && !bus.DONE;

  always_comb begin
    br_nz      = 1'b0;
    br_z       = 1'b0;
    br_abs     = 1'b0;
    reg_we     = 1'b0;
    reg_sel    = 1'b0;
    lut_in     = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    alu_sc_in  = 1'b0;
    rd_mem     = 1'b0;
    wr_mem     = 1'b0;
    alu_op     = 3'd0;
    if (dec_en) begin
      case (bus.opcode)
        4'd0, 4'd1, 4'd2, 4'd3, 4'd4: begin
          alu_op = bus.opcode[2:0];
          reg_we = 1'b1;
        end
        4'd5, 4'd6: begin
          // Shifts take their shift-in bit from fcode.
          alu_op    = bus.opcode[2:0];
          reg_we    = 1'b1;
          alu_sc_in = bus.fcode;
        end
        4'd7: begin
          alu_src = 1'b1;
          reg_we  = 1'b1;
        end
        4'd8: begin
          rd_mem     = 1'b1;
          mem_to_reg = 1'b1;
          reg_we     = 1'b1;
        end
        4'd9:  wr_mem = 1'b1;
        4'd10: br_z   = 1'b1;
        4'd11: br_nz  = 1'b1;
        4'd12: br_abs = 1'b1;
        4'd13: begin
          br_abs = 1'b1;
          lut_in = 1'b1;
        end
        4'd14: begin
          reg_sel = 1'b1;
          reg_we  = 1'b1;
        end
        default: alu_op = 3'd1; // CMP: SUB for flags, no writeback
      endcase
    end
  end

  assign bus.CTRL_branch_rel_nz = br_nz;
  assign bus.CTRL_branch_rel_z  = br_z;
  assign bus.CTRL_branch_abs    = br_abs;
  assign bus.CTRL_reg_write_en  = reg_we;
  assign bus.CTRL_reg_sel       = reg_sel;
  assign bus.CTRL_lut_in        = lut_in;
  assign bus.CTRL_mem_to_reg    = mem_to_reg;
  assign bus.CTRL_alu_src       = alu_src;
  assign bus.CTRL_alu_sc_in     = alu_sc_in;
  assign bus.CTRL_read_mem      = rd_mem;
  assign bus.CTRL_write_mem     = wr_mem;
  assign bus.CTRL_alu_op        = alu_op;

endmodule

// File: tb/tb_datapath_controller.sv
// Directed bench for datapath_controller: reset, normal/timeout/abort runs, decode sweep, mid-run reset.
// Latency: inputs driven 2 time units after the rising edge, outputs sampled after that.
// Backpressure: bench plays the host and holds host_req until ack (or drops it to abort).
module tb_datapath_controller;

  logic CLK = 1'b0;
  logic reset_n;
  always #5 CLK = ~CLK;

  datapath_controller_if bus ();

  datapath_controller #(
    .START_CYCLES(2),
    .MAX_CYCLES  (16'd20)
  ) dut (
    .CLK    (CLK),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int tests = 0;
  int fails = 0;

  // Scoreboards: {timeout, cycle_count} per completed run, and decoded control words.
  logic [16:0] exp_run_q[$];
  logic [13:0] exp_ctrl_q[$];

  localparam int B_BNZ = 13, B_BZ = 12, B_BA = 11, B_WE = 10, B_RS = 9, B_LUT = 8;
  localparam int B_M2R = 7, B_SRC = 6, B_SC = 5, B_RD = 4, B_WR = 3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  function automatic logic [13:0] obs_ctrl();
    return {bus.CTRL_branch_rel_nz, bus.CTRL_branch_rel_z, bus.CTRL_branch_abs,
            bus.CTRL_reg_write_en, bus.CTRL_reg_sel, bus.CTRL_lut_in, bus.CTRL_mem_to_reg,
            bus.CTRL_alu_src, bus.CTRL_alu_sc_in, bus.CTRL_read_mem, bus.CTRL_write_mem,
            bus.CTRL_alu_op};
  endfunction

  // Reference decode table, straight from the instruction list.
  function automatic logic [13:0] model_ctrl(input int op, input logic f);
    logic [13:0] v;
    v = '0;
    if (op <= 6) begin
      v[2:0]  = 3'(op);
      v[B_WE] = 1'b1;
      if (op == 5 || op == 6) v[B_SC] = f;
    end else begin
      case (op)
        7:  begin v[B_SRC] = 1'b1; v[B_WE] = 1'b1; end
        8:  begin v[B_RD] = 1'b1; v[B_M2R] = 1'b1; v[B_WE] = 1'b1; end
        9:  v[B_WR]  = 1'b1;
        10: v[B_BZ]  = 1'b1;
        11: v[B_BNZ] = 1'b1;
        12: v[B_BA]  = 1'b1;
        13: begin v[B_BA] = 1'b1; v[B_LUT] = 1'b1; end
        14: begin v[B_RS] = 1'b1; v[B_WE] = 1'b1; end
        default: v[2:0] = 3'd1;
      endcase
    end
    return v;
  endfunction

  // One host transaction. done_at/abort_at are RUN-cycle indices (0 = never);
  // sweep_f >= 0 drives opcodes 0..15 on RUN cycles 1..16 with that fcode.
  task automatic run_seq(input string name, input int done_at, input int abort_at,
                         input int sweep_f, input int exp_cc, input logic exp_to,
                         input int exp_busy);
    int          run_n;
    int          busy_n;
    int          start_busy_n;
    bit          finished;
    logic [16:0] exp_run;
    logic [13:0] exp_ctrl;
    run_n        = 0;
    busy_n       = 0;
    start_busy_n = 0;
    finished     = 1'b0;
    bus.opcode   = 4'd0;
    bus.fcode    = 1'b0;
    bus.DONE     = 1'b0;
    bus.host_req = 1'b1;
    if (abort_at == 0) exp_run_q.push_back({exp_to, 16'(exp_cc)});
    for (int c = 0; c < 200 && !finished; c++) begin
      tick();
      bus.DONE = 1'b0;
      if (bus.host_ack || !bus.host_req) begin
        finished = 1'b1;
      end else begin
        if (bus.busy) busy_n++;
        if (bus.busy && bus.START) start_busy_n++;
        if (bus.busy && !bus.START) begin
          run_n++;
          if (sweep_f >= 0 && run_n <= 16) begin
            bus.opcode = 4'(run_n - 1);
            bus.fcode  = sweep_f[0];
            exp_ctrl_q.push_back(model_ctrl(run_n - 1, sweep_f[0]));
            #1;
            exp_ctrl = exp_ctrl_q.pop_front();
            chk($sformatf("%s_dec_op%0d_f%0d", name, run_n - 1, sweep_f), 32'(obs_ctrl()), 32'(exp_ctrl));
            if (run_n - 1 == 8)
              chk($sformatf("%s_spot_lw", name), 32'(obs_ctrl()), 32'h0490);
            if (run_n - 1 == 13)
              chk($sformatf("%s_spot_jr", name), 32'(obs_ctrl()), 32'h0900);
            if (run_n - 1 == 5 && sweep_f == 1)
              chk($sformatf("%s_spot_shl_sc", name), 32'(obs_ctrl()), 32'h0425);
          end
          if (run_n == done_at) begin
            bus.DONE = 1'b1;
            #1;
            chk({name, "_ctrl_zero_on_done"}, 32'(obs_ctrl()), 32'h0);
          end
          if (run_n == abort_at) bus.host_req = 1'b0;
        end
      end
    end
    chk({name, "_completed_in_bound"}, 32'(finished), 32'd1);
    if (abort_at == 0) begin
      chk({name, "_ack"}, 32'(bus.host_ack), 32'd1);
      chk({name, "_busy_low"}, 32'(bus.busy), 32'd0);
      chk({name, "_start_frozen"}, 32'(bus.START), 32'd1);
      chk({name, "_busy_cycles"}, 32'(busy_n), 32'(exp_busy));
      chk({name, "_start_cycles"}, 32'(start_busy_n), 32'd2);
      if (exp_run_q.size() > 0) begin
        exp_run = exp_run_q.pop_front();
        chk({name, "_cycle_count"}, 32'(bus.cycle_count), 32'(exp_run[15:0]));
        chk({name, "_timeout"}, 32'(bus.timeout), 32'(exp_run[16]));
      end else begin
        chk({name, "_scoreboard_empty"}, 32'd0, 32'd1);
      end
      bus.host_req = 1'b0;
      tick();
      chk({name, "_ack_drop"}, 32'(bus.host_ack), 32'd0);
      chk({name, "_idle_busy"}, 32'(bus.busy), 32'd0);
    end else begin
      chk({name, "_no_ack"}, 32'(bus.host_ack), 32'd0);
      chk({name, "_busy_low"}, 32'(bus.busy), 32'd0);
      chk({name, "_start_high"}, 32'(bus.START), 32'd1);
      chk({name, "_ctrl_zero"}, 32'(obs_ctrl()), 32'h0);
      chk({name, "_cycle_count"}, 32'(bus.cycle_count), 32'(exp_cc));
      chk({name, "_timeout"}, 32'(bus.timeout), 32'd0);
      tick();
      chk({name, "_still_no_ack"}, 32'(bus.host_ack), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n      = 1'b0;
    bus.host_req = 1'b0;
    bus.opcode   = 4'd3;
    bus.fcode    = 1'b0;
    bus.DONE     = 1'b0;

    // Reset held: host_req toggling must not move anything.
    tick();
    bus.host_req = 1'b1;
    tick();
    tick();
    chk("rst_start", 32'(bus.START), 32'd1);
    chk("rst_ack", 32'(bus.host_ack), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ctrl", 32'(obs_ctrl()), 32'h0);
    chk("rst_cycle_count", 32'(bus.cycle_count), 32'd0);
    chk("rst_timeout", 32'(bus.timeout), 32'd0);
    bus.host_req = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    chk("idle_start", 32'(bus.START), 32'd1);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_ctrl", 32'(obs_ctrl()), 32'h0);

    // name, done_at, abort_at, sweep_f, exp_cc, exp_to, exp_busy
    run_seq("normal",     10, 0, -1, 10, 1'b0, 12);
    run_seq("timeout",     0, 0, -1, 20, 1'b1, 22);
    run_seq("abort",       0, 5, -1,  5, 1'b0,  0);
    run_seq("done_at_max",20, 0, -1, 20, 1'b0, 22);
    run_seq("sweep_f0",   17, 0,  0, 17, 1'b0, 19);
    run_seq("sweep_f1",   17, 0,  1, 17, 1'b0, 19);

    // Reset pulled in the middle of RUN cycle 3 with a store on the bus.
    bus.host_req = 1'b1;
    bus.opcode   = 4'd9;
    n = 0;
    for (int c = 0; c < 50 && n < 3; c++) begin
      tick();
      if (bus.busy && !bus.START) n++;
    end
    chk("midrst_reached_run3", 32'(n), 32'd3);
    #1;
    chk("midrst_wr_before", 32'(bus.CTRL_write_mem), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("midrst_wr_after", 32'(bus.CTRL_write_mem), 32'd0);
    chk("midrst_start", 32'(bus.START), 32'd1);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_ack", 32'(bus.host_ack), 32'd0);
    chk("midrst_cycle_count", 32'(bus.cycle_count), 32'd0);
    tick();
    reset_n      = 1'b1;
    bus.host_req = 1'b0;
    tick();
    chk("midrst_idle_busy", 32'(bus.busy), 32'd0);
    run_seq("after_reset", 10, 0, -1, 10, 1'b0, 12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
